hazard_scoreboard_unit: RTL
===========================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised load-use/long-latency hazard detector for the pipeline ID stage.
//  Keeps a per-register countdown of cycles until each in-flight result can be forwarded.
//  Stalls PC and IF/ID and inserts a bubble into ID/EX while any used source is pending.
//  Supports multi-cycle loads and mul/div, WAW overwrite, and EX-stage flush rollback.
// PARAMETERS
//  NUM_REGS  32  architectural registers; x0 is never tracked
//  ADDR_W    5   register index width, clog2(NUM_REGS)
//  CNT_W     3   countdown width; max latency = 2**CNT_W-1
//  PERF_W    16  width of the saturating stall counter
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  id_valid       in   1       instruction present in IF/ID
//  id_rs1         in   ADDR_W  source 1 index
//  id_rs2         in   ADDR_W  source 2 index
//  id_rs1_used    in   1       instruction reads rs1
//  id_rs2_used    in   1       instruction reads rs2
//  id_rd          in   ADDR_W  destination index
//  id_lat         in   CNT_W   cycles after issue until rd is forwardable; 0 = ALU op
//  ex_flush       in   1       taken branch/jump in EX; kills the ID and ID/EX instructions
//  PCWrite        out  1       PC write enable
//  IF_ID_write    out  1       IF/ID register write enable
//  detection_flush out 1       zero the ID/EX control fields (bubble)
//  stall_count    out  PERF_W  number of bubble cycles since reset, saturating
// BEHAVIOUR
//  State: cnt[1..NUM_REGS-1] (CNT_W each); last_rd, last_set, last_prev (CNT_W); stall_count.
//  Hazard (combinational, registered state only):
//   setnop = id_valid & ~ex_flush & ((id_rs1_used & id_rs1!=0 & cnt[id_rs1]!=0)
//            | (id_rs2_used & id_rs2!=0 & cnt[id_rs2]!=0)).
//   PCWrite = IF_ID_write = ~setnop; detection_flush = setnop.
//  issue = id_valid & ~setnop & ~ex_flush.
//  Per-cycle update, in priority order for each register r:
//   1. rst: all cnt=0, last_set=0, stall_count=0.
//   2. ex_flush & last_set & r==last_rd: cnt[r] <= sat_dec(last_prev).
//   3. issue & id_rd==r & r!=0 & id_lat!=0: cnt[r] <= id_lat. This is a WAW overwrite:
//      the youngest writer wins.
//   4. Otherwise: cnt[r] <= sat_dec(cnt[r]), where sat_dec(x) = x ? x-1 : 0.
//  Issue bookkeeping:
//   - On issue with id_rd!=0 and id_lat!=0: last_set<=1, last_rd<=id_rd,
//     last_prev<=sat_dec(cnt[id_rd]).
//   - In all other cases: last_set<=0.
//   - Rollback therefore restores the value the older writer would have had.
//  Timing for id_lat=1 (plain load): exactly one bubble when the next instruction uses rd.
//   With id_lat=N, the dependent waits N cycles.
//  A dependency on x0 never stalls. Unused sources are ignored.
//  A source whose register equals its own id_rd still checks the pre-issue cnt.
//  ex_flush and setnop are never both 1; the flush takes priority and the ID instruction is not issued.
//  stall_count increments on every setnop cycle and holds at all-ones.
//  rst mid-stall: the next cycle has all cnt=0 and PCWrite=1.
//  Outputs after reset: PCWrite=1, IF_ID_write=1, detection_flush=0, stall_count=0.
// TESTING
//  1. lw x5 (lat=1), then add x6,x5,x1 -> one cycle of PCWrite=0/detection_flush=1;
//     issues next cycle; stall_count=1.
//  2. div x7 (lat=4), then sub using x7 -> 4 stall cycles; an independent add between them
//     hides one stall (3 stalls).
//  3. lw x0 (lat=1), then add x1,x0,x0 -> no stall; rs2_used=0 with rs2=x5 pending -> no stall.
//  4. div x8 (lat=5), then next-cycle lw x8 (lat=1), then use of x8 -> stall 1 cycle only
//     (WAW youngest wins).
//  5. lw x9 (lat=3), add issues, then lw x9 (lat=1) followed by ex_flush -> cnt[x9] restored
//     to the old writer's residual value; the dependent stalls accordingly.
//  6. Pending x10 (lat=7) with rst asserted mid-stall -> next cycle PCWrite=1 and
//     stall_count=0; the counter saturates at 0xFFFF under a forced long stall.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard scoreboard: per-register countdown until each in-flight result is
// forwardable, with a load-use/long-latency stall, WAW overwrite and EX-flush rollback.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [CNT_W-1:0]  id_lat,
  input  logic              ex_flush,
  output logic              PCWrite,
  output logic              IF_ID_write,
  output logic              detection_flush,
  output logic [PERF_W-1:0] stall_count
);

  logic [CNT_W-1:0]  r_cnt [NUM_REGS];
  logic [ADDR_W-1:0] r_last_rd;
  logic              r_last_set;
  logic [CNT_W-1:0]  r_last_prev;
  logic [PERF_W-1:0] r_stall_count;

  logic w_rs1_pend;
  logic w_rs2_pend;
  logic w_setnop;
  logic w_issue;
  logic w_track;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] x);
    return (x != '0) ? x - CNT_W'(1) : '0;
  endfunction

  // Hazard looks only at registered counts, so a source equal to its own rd sees the older writer.
  assign w_rs1_pend = id_rs1_used && (id_rs1 != '0) && (r_cnt[id_rs1] != '0);
  assign w_rs2_pend = id_rs2_used && (id_rs2 != '0) && (r_cnt[id_rs2] != '0);
  assign w_setnop   = id_valid && !ex_flush && (w_rs1_pend || w_rs2_pend);
  assign w_issue    = id_valid && !w_setnop && !ex_flush;
  assign w_track    = w_issue && (id_rd != '0) && (id_lat != '0);

  always_ff @(posedge clk) begin
    // NOTE: the scoreboard array is reset, not left to drain -- a stale count would stall a restarted pipeline.
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_last_rd     <= '0;
      r_last_set    <= 1'b0;
      r_last_prev   <= '0;
      r_stall_count <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge snapshot of r_cnt.
      r_cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (ex_flush && r_last_set && (ADDR_W'(r) == r_last_rd))
          r_cnt[r] <= sat_dec(r_last_prev);
        else if (w_track && (id_rd == ADDR_W'(r)))
          r_cnt[r] <= id_lat;
        else
          r_cnt[r] <= sat_dec(r_cnt[r]);
      end

      // Remember what the older writer would hold next cycle, for a flush of this issue.
      r_last_set <= w_track;
      if (w_track) begin
        r_last_rd   <= id_rd;
        r_last_prev <= sat_dec(r_cnt[id_rd]);
      end

      if (w_setnop && (r_stall_count != '1))
        r_stall_count <= r_stall_count + PERF_W'(1);
    end
  end

  assign PCWrite         = !w_setnop;
  assign IF_ID_write     = !w_setnop;
  assign detection_flush = w_setnop;
  assign stall_count     = r_stall_count;

endmodule
